// File: rtl/vga_timgen_v2_if.sv
// Bus for vga_timgen_v2: enable, pixel tick, programmed timing/polarity
// fields and the generated timing outputs. master = register block side,
// slave = timing generator.
interface vga_timgen_v2_if #(
    parameter int TB_WIDTH  = 10,
    parameter int VB_WIDTH  = 16,
    parameter int CNT_WIDTH = 12
);
    logic                 en_i;
    logic                 pclk_en_i;
    logic [TB_WIDTH-1:0]  hsnsize_i, hbpsize_i, hfpsize_i;
    logic [VB_WIDTH-1:0]  hvlen_i;
    logic [TB_WIDTH-1:0]  vsnsize_i, vbpsize_i, vfpsize_i;
    logic [VB_WIDTH-1:0]  vvlen_i;
    logic                 hspol_i, vspol_i, blpol_i;
    logic [1:0]           mode_i;

    logic                 hsync_o, vsync_o, blank_o, de_o;
    logic [CNT_WIDTH-1:0] x_o, y_o;
    logic                 line_end_o, frame_end_o;
    logic [15:0]          tp_rgb_o;

    modport master (
        output en_i, pclk_en_i,
        output hsnsize_i, hbpsize_i, hfpsize_i, hvlen_i,
        output vsnsize_i, vbpsize_i, vfpsize_i, vvlen_i,
        output hspol_i, vspol_i, blpol_i, mode_i,
        input  hsync_o, vsync_o, blank_o, de_o, x_o, y_o,
        input  line_end_o, frame_end_o, tp_rgb_o
    );

    modport slave (
        input  en_i, pclk_en_i,
        input  hsnsize_i, hbpsize_i, hfpsize_i, hvlen_i,
        input  vsnsize_i, vbpsize_i, vfpsize_i, vvlen_i,
        input  hspol_i, vspol_i, blpol_i, mode_i,
        output hsync_o, vsync_o, blank_o, de_o, x_o, y_o,
        output line_end_o, frame_end_o, tp_rgb_o
    );
endinterface

// File: rtl/vga_timgen_v2.sv
// vga_timgen_v2: programmable VGA/LCD timing generator (pixel-clock domain).
// Independent H and V phase FSMs (SYNC, BACKPORCH, VISIBLE, FRONTPORCH),
// each with a down-counter reloaded from the next phase's size field.
// All outputs are registered on pixel ticks and describe the tick just taken.
// Optional colour-bar test pattern: define VGA_TESTPAT_EN.
module vga_timgen_v2 #(
    parameter int TB_WIDTH  = 10,
    parameter int VB_WIDTH  = 16,
    parameter int CNT_WIDTH = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    vga_timgen_v2_if.slave bus
);
    localparam int SW = (VB_WIDTH > TB_WIDTH) ? VB_WIDTH : TB_WIDTH;
    localparam logic [SW-1:0]        ONE_S = SW'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        BACKPORCH  = 2'd1,
        VISIBLE    = 2'd2,
        FRONTPORCH = 2'd3
    } phase_t;

    phase_t               h_state, h_next, v_state, v_next;
    logic [SW-1:0]        h_cnt, h_cnt_next, v_cnt, v_cnt_next;
    logic                 tick, h_last, v_last, h_vis, v_vis;
    logic                 line_tick, frame_tick;
    logic [CNT_WIDTH-1:0] h_pix, v_pix, x_q, y_q;
    logic                 hs_q, vs_q, de_q, blank_q, line_end_q, frame_end_q;

    assign tick       = bus.en_i & bus.pclk_en_i;
    assign h_last     = (h_cnt == '0);
    assign v_last     = (v_cnt == '0);
    assign h_vis      = (h_state == VISIBLE);
    assign v_vis      = (v_state == VISIBLE);
    assign line_tick  = tick & (h_state == FRONTPORCH) & h_last;
    assign frame_tick = line_tick & (v_state == FRONTPORCH) & v_last;

    // Phase state registers; a low enable parks both FSMs at SYNC with a zero count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_state <= SYNC;
            h_cnt   <= '0;
            v_state <= SYNC;
            v_cnt   <= '0;
        end else if (!bus.en_i) begin
            h_state <= SYNC;
            h_cnt   <= '0;
            v_state <= SYNC;
            v_cnt   <= '0;
        end else begin
            h_state <= h_next;
            h_cnt   <= h_cnt_next;
            v_state <= v_next;
            v_cnt   <= v_cnt_next;
        end
    end

    // Next phase: advance when the counter has expired and reload it with the
    // size of the phase being entered; V only moves on the last tick of a line
    always_comb begin
        h_next     = h_state;
        h_cnt_next = h_cnt;
        v_next     = v_state;
        v_cnt_next = v_cnt;
        if (tick) begin
            if (h_last) begin
                h_next = phase_t'(h_state + 2'd1);
                case (h_next)
                    SYNC:      h_cnt_next = SW'(bus.hsnsize_i);
                    BACKPORCH: h_cnt_next = SW'(bus.hbpsize_i);
                    VISIBLE:   h_cnt_next = SW'(bus.hvlen_i);
                    default:   h_cnt_next = SW'(bus.hfpsize_i);
                endcase
            end else begin
                h_cnt_next = h_cnt - ONE_S;
            end
        end
        if (line_tick) begin
            if (v_last) begin
                v_next = phase_t'(v_state + 2'd1);
                case (v_next)
                    SYNC:      v_cnt_next = SW'(bus.vsnsize_i);
                    BACKPORCH: v_cnt_next = SW'(bus.vbpsize_i);
                    VISIBLE:   v_cnt_next = SW'(bus.vvlen_i);
                    default:   v_cnt_next = SW'(bus.vfpsize_i);
                endcase
            end else begin
                v_cnt_next = v_cnt - ONE_S;
            end
        end
    end

    // Registered timing flags, coordinates and strobes; strobes last one clk
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; blank_q <= 1'b0;
            x_q <= '0; y_q <= '0; h_pix <= '0; v_pix <= '0;
            line_end_q <= 1'b0; frame_end_q <= 1'b0;
        end else if (!bus.en_i) begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; blank_q <= 1'b0;
            x_q <= '0; y_q <= '0; h_pix <= '0; v_pix <= '0;
            line_end_q <= 1'b0; frame_end_q <= 1'b0;
        end else if (tick) begin
            hs_q        <= (h_state == SYNC);
            vs_q        <= (v_state == SYNC);
            de_q        <= h_vis & v_vis;
            blank_q     <= ~(h_vis & v_vis);
            x_q         <= h_vis ? h_pix : '0;
            h_pix       <= h_vis ? h_pix + ONE_C : '0;
            y_q         <= v_vis ? v_pix : '0;
            line_end_q  <= line_tick;
            frame_end_q <= frame_tick;
            if (line_tick)
                v_pix <= v_vis ? v_pix + ONE_C : '0;
        end else begin
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end
    end

    assign bus.hsync_o     = hs_q ^ bus.hspol_i;
    assign bus.vsync_o     = vs_q ^ bus.vspol_i;
    assign bus.blank_o     = blank_q ^ bus.blpol_i;
    assign bus.de_o        = de_q;
    assign bus.x_o         = x_q;
    assign bus.y_o         = y_q;
    assign bus.line_end_o  = line_end_q;
    assign bus.frame_end_o = frame_end_q;

`ifdef VGA_TESTPAT_EN
    localparam logic [VB_WIDTH:0] ONE_W = (VB_WIDTH+1)'(1);

    logic [VB_WIDTH:0] bar_w, bar_cnt, w_raw;
    logic [2:0]        bar_idx;
    logic [15:0]       tp_q;

    // Bar colour = sum of the R/G/B component masks of the selected format;
    // bar index bits switch off B (bit0), R (bit1), G (bit2)
    function automatic logic [15:0] bar_rgb(input logic [1:0] mode, input logic [2:0] idx);
        logic [15:0] r, g, b;
        case (mode)
            2'b00:   begin r = 16'h00E0; g = 16'h001C; b = 16'h0003; end
            2'b01:   begin r = 16'h0F00; g = 16'h00F0; b = 16'h000F; end
            2'b10:   begin r = 16'h7C00; g = 16'h03E0; b = 16'h001F; end
            default: begin r = 16'hF800; g = 16'h07E0; b = 16'h001F; end
        endcase
        return (idx[1] ? 16'h0000 : r) | (idx[2] ? 16'h0000 : g) | (idx[0] ? 16'h0000 : b);
    endfunction

    assign w_raw = ({1'b0, bus.hvlen_i} + ONE_W) >> 3;

    // Bar width latched on entry to H VISIBLE; index saturates so the last
    // bar absorbs any remainder
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bar_w <= ONE_W; bar_cnt <= '0; bar_idx <= '0; tp_q <= '0;
        end else if (!bus.en_i) begin
            bar_w <= ONE_W; bar_cnt <= '0; bar_idx <= '0; tp_q <= '0;
        end else if (tick) begin
            tp_q <= (h_vis & v_vis) ? bar_rgb(bus.mode_i, bar_idx) : 16'h0000;
            if (h_state == BACKPORCH && h_last) begin
                bar_w   <= (w_raw == '0) ? ONE_W : w_raw;
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (h_vis) begin
                if (bar_cnt == bar_w - ONE_W) begin
                    bar_cnt <= '0;
                    if (bar_idx != 3'd7)
                        bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + ONE_W;
                end
            end
        end
    end

    assign bus.tp_rgb_o = tp_q;
`else
    logic unused_mode;
    assign unused_mode  = ^bus.mode_i;
    assign bus.tp_rgb_o = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_timgen_v2.sv
`timescale 1ns/1ps
module tb_vga_timgen_v2;
    localparam int TBW = 10;
    localparam int VBW = 16;
    localparam int CW  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timgen_v2_if #(.TB_WIDTH(TBW), .VB_WIDTH(VBW), .CNT_WIDTH(CW)) bus();
    vga_timgen_v2 #(.TB_WIDTH(TBW), .VB_WIDTH(VBW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    typedef struct {
        int hsn, hbp, hv, hfp, vsn, vbp, vv, vfp;
        bit hp, vp, bp;
        int mode;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   div;
        int   line_p, frame_p, lines, hs_tot, vs_tot, de_tot;
    } vec_t;

    typedef struct packed {
        logic hs, vs, de, bl, le, fe;
        logic [CW-1:0] x, y;
        logic [15:0] tp;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   pc = 0;
    exp_t q[$];
    vec_t vt[4];

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pc++;
    endtask

    function automatic cfg_t mk_cfg(int hsn, int hbp, int hv, int hfp, int vsn, int vbp,
                                    int vv, int vfp, bit hp, bit vp, bit bp, int mode);
        cfg_t c;
        c.hsn = hsn; c.hbp = hbp; c.hv = hv; c.hfp = hfp;
        c.vsn = vsn; c.vbp = vbp; c.vv = vv; c.vfp = vfp;
        c.hp = hp; c.vp = vp; c.bp = bp; c.mode = mode;
        return c;
    endfunction

    function automatic vec_t mk_vec(cfg_t c, int div, int lp, int fp, int ln, int hs, int vs, int de);
        vec_t v;
        v.c = c; v.div = div; v.line_p = lp; v.frame_p = fp;
        v.lines = ln; v.hs_tot = hs; v.vs_tot = vs; v.de_tot = de;
        return v;
    endfunction

    function automatic logic [15:0] ref_rgb(int mode, int idx);
        logic [15:0] row[8];
        case (mode)
            0:       row = '{16'h00FF, 16'h00FC, 16'h001F, 16'h001C, 16'h00E3, 16'h00E0, 16'h0003, 16'h0000};
            1:       row = '{16'h0FFF, 16'h0FF0, 16'h00FF, 16'h00F0, 16'h0F0F, 16'h0F00, 16'h000F, 16'h0000};
            2:       row = '{16'h7FFF, 16'h7FE0, 16'h03FF, 16'h03E0, 16'h7C1F, 16'h7C00, 16'h001F, 16'h0000};
            default: row = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        endcase
        return row[idx];
    endfunction

    task automatic apply_cfg(cfg_t c);
        bus.hsnsize_i = TBW'(c.hsn); bus.hbpsize_i = TBW'(c.hbp);
        bus.hvlen_i   = VBW'(c.hv);  bus.hfpsize_i = TBW'(c.hfp);
        bus.vsnsize_i = TBW'(c.vsn); bus.vbpsize_i = TBW'(c.vbp);
        bus.vvlen_i   = VBW'(c.vv);  bus.vfpsize_i = TBW'(c.vfp);
        bus.hspol_i = c.hp; bus.vspol_i = c.vp; bus.blpol_i = c.bp;
        bus.mode_i  = 2'(c.mode);
    endtask

    // Restart the generator: one clk with en low, then enable
    task automatic restart(cfg_t c);
        apply_cfg(c);
        bus.en_i = 1'b0; bus.pclk_en_i = 1'b0;
        step();
        bus.en_i = 1'b1;
    endtask

    // Per-tick expected outputs laid out segment by segment; the first line
    // and first frame start from a zero-count SYNC (one tick / one line)
    task automatic build(cfg_t c, int nticks);
        int   hl[4], vl[4];
        int   len, vlen, w, idx;
        exp_t e;
        hl = '{c.hsn + 1, c.hbp + 1, c.hv + 1, c.hfp + 1};
        vl = '{c.vsn + 1, c.vbp + 1, c.vv + 1, c.vfp + 1};
        w  = (c.hv + 1) / 8;
        if (w == 0) w = 1;
        q.delete();
        for (int f = 0; q.size() < nticks; f++)
            for (int vs = 0; vs < 4; vs++) begin
                vlen = (f == 0 && vs == 0) ? 1 : vl[vs];
                for (int l = 0; l < vlen; l++)
                    for (int hs = 0; hs < 4; hs++) begin
                        len = (f == 0 && vs == 0 && l == 0 && hs == 0) ? 1 : hl[hs];
                        for (int t = 0; t < len; t++) begin
                            e.hs = (hs == 0);
                            e.vs = (vs == 0);
                            e.de = (hs == 2 && vs == 2);
                            e.bl = !e.de;
                            e.x  = (hs == 2) ? CW'(t) : '0;
                            e.y  = (vs == 2) ? CW'(l) : '0;
                            e.le = (hs == 3 && t == len - 1);
                            e.fe = e.le && vs == 3 && l == vlen - 1;
                            idx  = t / w;
                            if (idx > 7) idx = 7;
                            e.tp = '0;
`ifdef VGA_TESTPAT_EN
                            if (e.de) e.tp = ref_rgb(c.mode, idx);
`endif
                            q.push_back(e);
                        end
                    end
            end
    endtask

    // Compare every clk against the model for nticks pixel ticks; pct = tick density
    task automatic run_model(string name, cfg_t c, int nticks, int pct);
        exp_t cur, e;
        logic [45:0] act, expv, first_act, first_exp;
        int   n, nbad, first_cyc, cyc;
        bit   t;
        build(c, nticks);
        restart(c);
        cur = '0;
        n = 0; nbad = 0; cyc = 0; first_cyc = 0; first_act = '0; first_exp = '0;
        while (n < nticks && cyc < 20 * nticks + 100) begin
            t = ($urandom_range(99) < pct);
            bus.pclk_en_i = t;
            step();
            cyc++;
            if (t) begin
                cur = q.pop_front();
                n++;
            end
            e = cur;
            if (!t) begin e.le = 1'b0; e.fe = 1'b0; end
            act  = {bus.hsync_o, bus.vsync_o, bus.blank_o, bus.de_o, bus.line_end_o,
                    bus.frame_end_o, bus.x_o, bus.y_o, bus.tp_rgb_o};
            expv = {e.hs ^ c.hp, e.vs ^ c.vp, e.bl ^ c.bp, e.de, e.le, e.fe, e.x, e.y, e.tp};
            if (act !== expv) begin
                if (nbad == 0) begin first_cyc = cyc; first_act = act; first_exp = expv; end
                nbad++;
            end
        end
        checks++;
        if (nbad != 0 || n < nticks) begin
            errors++;
            $display("FAIL %s: %0d bad clks (ticks %0d/%0d), first at clk %0d got %h want %h (hs,vs,bl,de,le,fe,x,y,tp)",
                     name, nbad, n, nticks, first_cyc, first_act, first_exp);
        end
    endtask

    // Run one steady frame (after the first frame_end) and compare its totals
    task automatic measure(vec_t v, int id);
        int  fp, lp, ln, hs, vs, de, bl, fe_nol;
        bit  got;
        restart(v.c);
        got = 0;
        for (int i = 0; i < 8000 && !got; i++) begin
            bus.pclk_en_i = (pc % v.div == 0);
            step();
            if (bus.frame_end_o) got = 1;
        end
        check($sformatf("vec%0d first frame_end", id), got, 1);
        fp = 0; lp = 0; ln = 0; hs = 0; vs = 0; de = 0; bl = 0; fe_nol = 0; got = 0;
        for (int i = 0; i < 8000 && !got; i++) begin
            bus.pclk_en_i = (pc % v.div == 0);
            step();
            fp++;
            if (bus.line_end_o && lp == 0) lp = fp;
            ln += int'(bus.line_end_o);
            hs += int'(bus.hsync_o ^ v.c.hp);
            vs += int'(bus.vsync_o ^ v.c.vp);
            bl += int'(bus.blank_o ^ v.c.bp);
            de += int'(bus.de_o);
            if (bus.frame_end_o && !bus.line_end_o) fe_nol++;
            if (bus.frame_end_o) got = 1;
        end
        check($sformatf("vec%0d frame period", id), fp, v.frame_p);
        check($sformatf("vec%0d line period", id), lp, v.line_p);
        check($sformatf("vec%0d lines/frame", id), ln, v.lines);
        check($sformatf("vec%0d hsync clks", id), hs, v.hs_tot);
        check($sformatf("vec%0d vsync clks", id), vs, v.vs_tot);
        check($sformatf("vec%0d de clks", id), de, v.de_tot);
        check($sformatf("vec%0d blank clks", id), bl, v.frame_p - v.de_tot);
        check($sformatf("vec%0d frame_end w/o line_end", id), fe_nol, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c, base, pol;
        int   cnt, maxx;
        bit   got;

        base = mk_cfg(1, 1, 7, 0, 0, 0, 3, 0, 0, 0, 0, 3);
        pol  = mk_cfg(1, 1, 7, 0, 0, 0, 3, 0, 1, 1, 1, 3);
        vt[0] = mk_vec(base, 1, 13, 91, 7, 14, 13, 32);
        vt[1] = mk_vec(pol, 2, 26, 182, 7, 28, 26, 64);
        vt[2] = mk_vec(mk_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 4, 16, 4, 4, 4, 1);
        vt[3] = mk_vec(mk_cfg(3, 2, 15, 1, 1, 0, 2, 1, 0, 1, 0, 1), 3, 75, 600, 8, 96, 150, 144);

        apply_cfg(base);
        bus.en_i = 1'b0; bus.pclk_en_i = 1'b0;
        #1;
        // Reset values while rst is held
        check("reset hsync", bus.hsync_o, 0);
        check("reset vsync/blank/de", {bus.vsync_o, bus.blank_o, bus.de_o}, 0);
        check("reset x/y", {bus.x_o, bus.y_o}, 0);
        check("reset strobes/tp", {bus.line_end_o, bus.frame_end_o, bus.tp_rgb_o}, 0);
        step(); step();
        rst = 1'b0;

        // Table-driven period/duration vectors
        for (int i = 0; i < 4; i++) measure(vt[i], i);

        // Model-checked sequences: nominal, polarity with sparse ticks, x wrap
        run_model("model base", base, 2 * 91, 100);
        run_model("model pol sparse", pol, 2 * 91, 50);
        run_model("model x wrap", mk_cfg(0, 0, 4099, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4200, 100);
        for (int r = 0; r < 8; r++) begin
            c = mk_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 24),
                       $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                       $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            run_model($sformatf("model rand%0d", r), c,
                      2 * (c.hsn + c.hbp + c.hv + c.hfp + 4) * (c.vsn + c.vbp + c.vv + c.vfp + 4),
                      $urandom_range(40, 100));
        end

        // Enable drop mid-visible, then re-enable
        restart(base);
        bus.pclk_en_i = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (bus.de_o && bus.x_o == 3) got = 1;
        end
        check("en drop: reached x=3", got, 1);
        bus.en_i = 1'b0;
        step();
        check("en drop: de", bus.de_o, 0);
        check("en drop: x", bus.x_o, 0);
        check("en drop: hsync", bus.hsync_o, 0);
        bus.en_i = 1'b1; bus.pclk_en_i = 1'b0;
        step();
        check("re-enable: hsync before tick", bus.hsync_o, 0);
        bus.pclk_en_i = 1'b1;
        step();
        check("re-enable: hsync after first tick", {bus.hsync_o, bus.vsync_o}, 2'b11);

        // Async reset mid-line with inverted polarities
        restart(pol);
        bus.pclk_en_i = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (bus.de_o && bus.x_o == 4) got = 1;
        end
        check("async rst: reached x=4", got, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst: sync/blank pins", {bus.hsync_o, bus.vsync_o, bus.blank_o}, 3'b111);
        check("async rst: de/x", {bus.de_o, bus.x_o}, 0);
        step();
        check("async rst held: hsync", bus.hsync_o, 1);
        rst = 1'b0;

        // hvlen change during H VISIBLE takes effect on the next line only
        c = mk_cfg(1, 1, 7, 0, 0, 0, 20, 0, 0, 0, 0, 3);
        restart(c);
        bus.pclk_en_i = 1'b1;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            step();
            if (bus.de_o && bus.x_o == 0 && bus.y_o == 5) got = 1;
        end
        check("cfg sample: reached y=5 x=0", got, 1);
        bus.hvlen_i = VBW'(15);
        cnt = 1; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            cnt += int'(bus.de_o);
            if (bus.line_end_o) got = 1;
        end
        check("cfg sample: current line px", cnt, 8);
        cnt = 0; maxx = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            cnt += int'(bus.de_o);
            if (bus.de_o && int'(bus.x_o) > maxx) maxx = int'(bus.x_o);
            if (bus.line_end_o) got = 1;
        end
        check("cfg sample: next line px", cnt, 16);
        check("cfg sample: next line max x", maxx, 15);

`ifdef VGA_TESTPAT_EN
        // Colour bars, 2 px per bar, RGB565 then RGB332
        restart(mk_cfg(1, 1, 15, 0, 0, 0, 3, 0, 0, 0, 0, 3));
        bus.pclk_en_i = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (bus.de_o && bus.x_o == 0) got = 1;
        end
        check("tp: reached first px", got, 1);
        for (int p = 0; p < 16; p++) begin
            check($sformatf("tp565 px%0d", p), bus.tp_rgb_o, ref_rgb(3, p / 2));
            step();
        end
        bus.mode_i = 2'b00;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (bus.de_o && bus.x_o == 0) got = 1;
        end
        check("tp332 first px", bus.tp_rgb_o, 16'h00FF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
